// File: rtl/memory_read_demux_pkg.sv
// Shared definitions for the memory read demultiplexer.
//   - default data/address widths
//   - read-mode encodings {Read_Files, File_Type, Read_Layer}
//   - controller state encoding
//   - mode legality helper
package memory_read_demux_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ADDR_W = 16;

    localparam logic [2:0] MODE_DUMP  = 3'b100;
    localparam logic [2:0] MODE_FILE  = 3'b110;
    localparam logic [2:0] MODE_LAYER = 3'b001;
    localparam logic [2:0] MODE_CNN   = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    function automatic logic mode_is_legal(input logic [2:0] mode);
        logic legal;
        legal = 1'b0;
        case (mode)
            MODE_DUMP, MODE_FILE, MODE_LAYER, MODE_CNN: legal = 1'b1;
            default:                                    legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/memory_read_demux_read_latency_pipe.sv
// In-flight read tracker: a LATENCY-deep shift register of read strobes.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push        - a read was issued this cycle
//   tail        - the read issued LATENCY cycles ago has its data on the bus now
//   empty       - no read is in flight
//   tail_only   - the only read in flight is the one at the tail (drains this cycle)
module read_latency_pipe #(
    parameter int LATENCY = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    output logic tail,
    output logic empty,
    output logic tail_only
);

    logic stage [LATENCY];
    logic any_set;
    logic head_set;

    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
        if (gi == 0) begin : g_first
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) stage[gi] <= 1'b0;
                else        stage[gi] <= push;
            end
        end else begin : g_rest
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) stage[gi] <= 1'b0;
                else        stage[gi] <= stage[gi-1];
            end
        end
    end

    // head_set covers every stage except the tail
    always_comb begin
        any_set  = 1'b0;
        head_set = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            any_set = any_set | stage[i];
            if (i < LATENCY - 1) head_set = head_set | stage[i];
        end
    end

    assign tail      = stage[LATENCY-1];
    assign empty     = ~any_set;
    assign tail_only = stage[LATENCY-1] & ~head_set;

endmodule

// File: rtl/memory_read_demux.sv
// Read-side demultiplexer for the shared feature/weight memory.
// Latches a read mode, base address and length on Start, streams reads out of
// the single-port memory and routes each returned word to one consumer.
// Ports:
//   clk, rst_n                          - clock, asynchronous active-low reset
//   Start, Read_Files/File_Type/Read_Layer, Base_Addr, Length - request
//   Pause                               - holds off new reads (in-flight ones still land)
//   Mem_Read, Mem_Addr, Mem_Data_In     - memory read port
//   Out_Data, Valid_Dump/File/Layer/CNN - registered word + per-consumer valid
//   Busy, Done, Mode_Err                - status
// READ_LATENCY must be in 1..4.
module memory_read_demux
    import memory_read_demux_pkg::*;
#(
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int ADDR_W       = DEFAULT_ADDR_W,
    parameter int READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Start,
    input  logic              Read_Files,
    input  logic              File_Type,
    input  logic              Read_Layer,
    input  logic [ADDR_W-1:0] Base_Addr,
    input  logic [ADDR_W-1:0] Length,
    input  logic              Pause,
    output logic              Mem_Read,
    output logic [ADDR_W-1:0] Mem_Addr,
    input  logic [DATA_W-1:0] Mem_Data_In,
    output logic [DATA_W-1:0] Out_Data,
    output logic              Valid_Dump,
    output logic              Valid_File,
    output logic              Valid_Layer,
    output logic              Valid_CNN,
    output logic              Busy,
    output logic              Done,
    output logic              Mode_Err
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [ADDR_W-1:0] count_reg, count_next;
    logic [2:0]        mode_reg, mode_next;
    logic [DATA_W-1:0] out_data_reg;
    logic [3:0]        valid_reg;      // {dump, file, layer, cnn}
    logic              done_reg;
    logic              mode_err_reg;
    logic              mode_err_next;
    logic              read_now;

    logic              pipe_tail;
    logic              pipe_empty;
    logic              pipe_tail_only;

    logic [2:0]        req_mode;
    assign req_mode = {Read_Files, File_Type, Read_Layer};

    read_latency_pipe #(
        .LATENCY (READ_LATENCY)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (read_now),
        .tail      (pipe_tail),
        .empty     (pipe_empty),
        .tail_only (pipe_tail_only)
    );

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        count_next    = count_reg;
        mode_next     = mode_reg;
        mode_err_next = 1'b0;
        read_now      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (Start) begin
                    if (mode_is_legal(req_mode)) begin
                        mode_next  = req_mode;
                        addr_next  = Base_Addr;
                        count_next = Length;
                        state_next = (Length == '0) ? ST_FINISH : ST_ISSUE;
                    end else begin
                        mode_err_next = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (!Pause) begin
                    read_now   = 1'b1;
                    addr_next  = addr_reg + 1'b1;
                    count_next = count_reg - 1'b1;
                    if (count_reg == ADDR_W'(1)) state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave once the last word is on the bus this cycle; it is
                // registered on this edge, so its Valid_* shows up during
                // FINISH and Done (registered) follows one cycle later.
                if (pipe_empty || pipe_tail_only) state_next = ST_FINISH;
            end
            ST_FINISH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            count_reg    <= '0;
            mode_reg     <= '0;
            out_data_reg <= '0;
            valid_reg    <= '0;
            done_reg     <= 1'b0;
            mode_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            count_reg    <= count_next;
            mode_reg     <= mode_next;
            done_reg     <= (state_reg == ST_FINISH);
            mode_err_reg <= mode_err_next;
            if (pipe_tail) begin
                out_data_reg <= Mem_Data_In;
                valid_reg    <= {mode_reg == MODE_DUMP, mode_reg == MODE_FILE,
                                 mode_reg == MODE_LAYER, mode_reg == MODE_CNN};
            end else begin
                valid_reg    <= '0;
            end
        end
    end

    assign Mem_Read    = read_now;
    assign Mem_Addr    = addr_reg;
    assign Out_Data    = out_data_reg;
    assign Valid_Dump  = valid_reg[3];
    assign Valid_File  = valid_reg[2];
    assign Valid_Layer = valid_reg[1];
    assign Valid_CNN   = valid_reg[0];
    // Busy drops in the cycle Done is presented
    assign Busy        = (state_reg != ST_IDLE);
    assign Done        = done_reg;
    assign Mode_Err    = mode_err_reg;

endmodule

// File: tb/tb_memory_read_demux.sv
module tb_memory_read_demux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Start = 1'b0;
    logic        Read_Files = 1'b0, File_Type = 1'b0, Read_Layer = 1'b0;
    logic [15:0] Base_Addr = '0, Length = '0;
    logic        Pause = 1'b0;
    logic        Mem_Read;
    logic [15:0] Mem_Addr;
    logic [15:0] Mem_Data_In;
    logic [15:0] Out_Data;
    logic        Valid_Dump, Valid_File, Valid_Layer, Valid_CNN;
    logic        Busy, Done, Mode_Err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    memory_read_demux #(.DATA_W(16), .ADDR_W(16), .READ_LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start),
        .Read_Files(Read_Files), .File_Type(File_Type), .Read_Layer(Read_Layer),
        .Base_Addr(Base_Addr), .Length(Length), .Pause(Pause),
        .Mem_Read(Mem_Read), .Mem_Addr(Mem_Addr), .Mem_Data_In(Mem_Data_In),
        .Out_Data(Out_Data), .Valid_Dump(Valid_Dump), .Valid_File(Valid_File),
        .Valid_Layer(Valid_Layer), .Valid_CNN(Valid_CNN),
        .Busy(Busy), .Done(Done), .Mode_Err(Mode_Err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents model and a 2-cycle read pipe
    function automatic logic [15:0] memf(input logic [15:0] a);
        return a * 16'd7 + 16'h03C1;
    endfunction

    logic [15:0] mem_p1 = 16'hDEAD, mem_p2 = 16'hDEAD;
    always @(posedge clk) begin
        mem_p1 <= Mem_Read ? memf(Mem_Addr) : 16'hDEAD;
        mem_p2 <= mem_p1;
    end
    assign Mem_Data_In = mem_p2;

    // Event monitor, sampled mid-cycle
    int          rd_cyc[$];
    logic [15:0] rd_addr[$];
    int          v_cyc[$];
    logic [3:0]  v_kind[$];
    logic [15:0] v_data[$];
    int          done_cyc[$];
    int          err_cyc[$];
    int          busy_cnt  = 0;
    int          multi_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (Mem_Read) begin
                rd_cyc.push_back(cyc);
                rd_addr.push_back(Mem_Addr);
            end
            if (Valid_Dump | Valid_File | Valid_Layer | Valid_CNN) begin
                v_cyc.push_back(cyc);
                v_kind.push_back({Valid_Dump, Valid_File, Valid_Layer, Valid_CNN});
                v_data.push_back(Out_Data);
            end
            if ($countones({Valid_Dump, Valid_File, Valid_Layer, Valid_CNN}) > 1)
                multi_cnt = multi_cnt + 1;
            if (Done)     done_cyc.push_back(cyc);
            if (Mode_Err) err_cyc.push_back(cyc);
            if (Busy)     busy_cnt = busy_cnt + 1;
        end
    end

    task automatic clear_log();
        rd_cyc.delete(); rd_addr.delete();
        v_cyc.delete(); v_kind.delete(); v_data.delete();
        done_cyc.delete(); err_cyc.delete();
        busy_cnt = 0;
    endtask

    // Drives a one-cycle Start; s = cycle in which Start is high.
    // Inputs are scrambled afterwards so any sampling while busy shows up.
    task automatic start_txn(input logic [2:0] m, input logic [15:0] b,
                             input logic [15:0] l, output int s);
        @(posedge clk); #1;
        clear_log();
        Start = 1'b1;
        {Read_Files, File_Type, Read_Layer} = m;
        Base_Addr = b;
        Length = l;
        s = cyc;
        @(posedge clk); #1;
        Start = 1'b0;
        {Read_Files, File_Type, Read_Layer} = 3'b101;
        Base_Addr = 16'hBEEF;
        Length = 16'h0077;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (done_cyc.size() > 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({Mem_Read, Mem_Addr, Out_Data, Valid_Dump, Valid_File, Valid_Layer,
             Valid_CNN, Busy, Done, Mode_Err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rd=%b addr=%h data=%h v=%b%b%b%b busy=%b done=%b err=%b, want all 0",
                     Mem_Read, Mem_Addr, Out_Data, Valid_Dump, Valid_File, Valid_Layer,
                     Valid_CNN, Busy, Done, Mode_Err);
        end
        rst_n = 1'b1;
        $display("reset: checked idle outputs");
    endtask

    task automatic test_file_readback();
        int s; bit ok;
        start_txn(3'b110, 16'h0010, 16'd4, s);
        wait_done(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL file_timeout: got no Done, want Done"); end
        n_checks++;
        if (rd_cyc.size() != 4) begin n_fail++; $display("FAIL file_rd_count: got %0d, want 4", rd_cyc.size()); end
        for (int i = 0; i < rd_cyc.size() && i < 4; i++) begin
            n_checks++;
            if (rd_cyc[i] != s + 1 + i || rd_addr[i] !== 16'h0010 + 16'(i)) begin
                n_fail++;
                $display("FAIL file_rd[%0d]: got cyc+%0d addr %h, want cyc+%0d addr %h",
                         i, rd_cyc[i] - s, rd_addr[i], 1 + i, 16'h0010 + 16'(i));
            end
        end
        n_checks++;
        if (v_cyc.size() != 4) begin n_fail++; $display("FAIL file_v_count: got %0d, want 4", v_cyc.size()); end
        for (int i = 0; i < v_cyc.size() && i < 4; i++) begin
            n_checks++;
            if (v_cyc[i] != s + 4 + i || v_kind[i] !== 4'b0100 || v_data[i] !== memf(16'h0010 + 16'(i))) begin
                n_fail++;
                $display("FAIL file_v[%0d]: got cyc+%0d kind %b data %h, want cyc+%0d kind 0100 data %h",
                         i, v_cyc[i] - s, v_kind[i], v_data[i], 4 + i, memf(16'h0010 + 16'(i)));
            end
        end
        n_checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != s + 8) begin
            n_fail++;
            $display("FAIL file_done: got %0d pulses first at cyc+%0d, want 1 at cyc+8",
                     done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] - s : -1);
        end
        n_checks++;
        if (busy_cnt != 7) begin n_fail++; $display("FAIL file_busy: got %0d cycles, want 7", busy_cnt); end
        $display("file readback: base 0010 len 4, %0d reads %0d words", rd_cyc.size(), v_cyc.size());
    endtask

    task automatic test_pause();
        int s; bit ok;
        int          exp_rc[3] = '{1, 4, 5};
        logic [15:0] exp_a[3]  = '{16'h0000, 16'h0001, 16'h0002};
        int          exp_vc[3] = '{4, 7, 8};
        start_txn(3'b001, 16'h0000, 16'd3, s);
        @(posedge clk); #1; Pause = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1; Pause = 1'b0;
        wait_done(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL pause_timeout: got no Done, want Done"); end
        n_checks++;
        if (rd_cyc.size() != 3 || v_cyc.size() != 3) begin
            n_fail++;
            $display("FAIL pause_counts: got %0d reads %0d words, want 3 and 3", rd_cyc.size(), v_cyc.size());
        end
        for (int i = 0; i < rd_cyc.size() && i < 3; i++) begin
            n_checks++;
            if (rd_cyc[i] != s + exp_rc[i] || rd_addr[i] !== exp_a[i]) begin
                n_fail++;
                $display("FAIL pause_rd[%0d]: got cyc+%0d addr %h, want cyc+%0d addr %h",
                         i, rd_cyc[i] - s, rd_addr[i], exp_rc[i], exp_a[i]);
            end
        end
        for (int i = 0; i < v_cyc.size() && i < 3; i++) begin
            n_checks++;
            if (v_cyc[i] != s + exp_vc[i] || v_kind[i] !== 4'b0010 || v_data[i] !== memf(exp_a[i])) begin
                n_fail++;
                $display("FAIL pause_v[%0d]: got cyc+%0d kind %b data %h, want cyc+%0d kind 0010 data %h",
                         i, v_cyc[i] - s, v_kind[i], v_data[i], exp_vc[i], memf(exp_a[i]));
            end
        end
        n_checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != s + 9) begin
            n_fail++;
            $display("FAIL pause_done: got %0d pulses first at cyc+%0d, want 1 at cyc+9",
                     done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] - s : -1);
        end
        $display("layer load with pause: %0d reads %0d words", rd_cyc.size(), v_cyc.size());
    endtask

    task automatic test_wrap();
        int s; bit ok;
        logic [15:0] exp_a[4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        start_txn(3'b011, 16'hFFFE, 16'd4, s);
        wait_done(ok);
        n_checks++;
        if (!ok || rd_cyc.size() != 4 || v_cyc.size() != 4) begin
            n_fail++;
            $display("FAIL wrap_counts: got done=%0b %0d reads %0d words, want done 4 4", ok, rd_cyc.size(), v_cyc.size());
        end
        for (int i = 0; i < rd_cyc.size() && i < 4; i++) begin
            n_checks++;
            if (rd_addr[i] !== exp_a[i]) begin
                n_fail++;
                $display("FAIL wrap_rd[%0d]: got addr %h, want %h", i, rd_addr[i], exp_a[i]);
            end
        end
        for (int i = 0; i < v_cyc.size() && i < 4; i++) begin
            n_checks++;
            if (v_kind[i] !== 4'b0001 || v_data[i] !== memf(exp_a[i])) begin
                n_fail++;
                $display("FAIL wrap_v[%0d]: got kind %b data %h, want kind 0001 data %h",
                         i, v_kind[i], v_data[i], memf(exp_a[i]));
            end
        end
        $display("cnn wraparound: base fffe len 4, %0d reads %0d words", rd_cyc.size(), v_cyc.size());
    endtask

    task automatic test_zero_length();
        int s; bit ok;
        start_txn(3'b100, 16'h0123, 16'd0, s);
        wait_done(ok);
        n_checks++;
        if (!ok || done_cyc.size() != 1 || done_cyc[0] != s + 2) begin
            n_fail++;
            $display("FAIL zero_done: got %0d pulses first at cyc+%0d, want 1 at cyc+2",
                     done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] - s : -1);
        end
        n_checks++;
        if (rd_cyc.size() != 0 || v_cyc.size() != 0 || busy_cnt != 1) begin
            n_fail++;
            $display("FAIL zero_activity: got %0d reads %0d words busy %0d, want 0 0 1",
                     rd_cyc.size(), v_cyc.size(), busy_cnt);
        end
        $display("dump len 0: busy %0d cycle(s)", busy_cnt);
    endtask

    task automatic test_mode_err_and_ignore();
        int s; bit ok;
        start_txn(3'b010, 16'h0020, 16'd4, s);
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (err_cyc.size() != 1 || err_cyc[0] != s + 1) begin
            n_fail++;
            $display("FAIL mode_err_pulse: got %0d pulses first at cyc+%0d, want 1 at cyc+1",
                     err_cyc.size(), err_cyc.size() > 0 ? err_cyc[0] - s : -1);
        end
        n_checks++;
        if (rd_cyc.size() != 0 || busy_cnt != 0 || done_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL mode_err_side: got %0d reads busy %0d done %0d, want 0 0 0",
                     rd_cyc.size(), busy_cnt, done_cyc.size());
        end
        $display("illegal mode 010: %0d error pulse(s)", err_cyc.size());

        start_txn(3'b100, 16'h0040, 16'd8, s);
        @(posedge clk); #1;
        @(posedge clk); #1;
        Start = 1'b1; {Read_Files, File_Type, Read_Layer} = 3'b110;
        Base_Addr = 16'h0000; Length = 16'd2;
        @(posedge clk); #1;
        Start = 1'b0;
        wait_done(ok);
        n_checks++;
        if (!ok || rd_cyc.size() != 8 || v_cyc.size() != 8 || err_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL ignore_counts: got done=%0b %0d reads %0d words %0d errs, want done 8 8 0",
                     ok, rd_cyc.size(), v_cyc.size(), err_cyc.size());
        end
        for (int i = 0; i < v_cyc.size() && i < 8; i++) begin
            n_checks++;
            if (rd_addr[i] !== 16'h0040 + 16'(i) || v_kind[i] !== 4'b1000 || v_data[i] !== memf(16'h0040 + 16'(i))) begin
                n_fail++;
                $display("FAIL ignore_word[%0d]: got addr %h kind %b data %h, want addr %h kind 1000 data %h",
                         i, rd_addr[i], v_kind[i], v_data[i], 16'h0040 + 16'(i), memf(16'h0040 + 16'(i)));
            end
        end
        n_checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != s + 12) begin
            n_fail++;
            $display("FAIL ignore_done: got %0d pulses first at cyc+%0d, want 1 at cyc+12",
                     done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] - s : -1);
        end
        $display("busy restart ignored: %0d reads %0d words", rd_cyc.size(), v_cyc.size());
    endtask

    task automatic test_reset_abort();
        int s; bit ok;
        start_txn(3'b110, 16'h0080, 16'd8, s);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({Mem_Read, Mem_Addr, Out_Data, Valid_Dump, Valid_File, Valid_Layer,
             Valid_CNN, Busy, Done, Mode_Err} !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: got rd=%b addr=%h data=%h v=%b%b%b%b busy=%b done=%b, want all 0",
                     Mem_Read, Mem_Addr, Out_Data, Valid_Dump, Valid_File, Valid_Layer,
                     Valid_CNN, Busy, Done);
        end
        n_checks++;
        if (rd_cyc.size() != 3) begin n_fail++; $display("FAIL abort_rd_count: got %0d, want 3", rd_cyc.size()); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_log();
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (rd_cyc.size() != 0 || v_cyc.size() != 0 || done_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL abort_quiet: got %0d reads %0d words %0d done, want 0 0 0",
                     rd_cyc.size(), v_cyc.size(), done_cyc.size());
        end
        start_txn(3'b001, 16'h0005, 16'd2, s);
        wait_done(ok);
        n_checks++;
        if (!ok || v_cyc.size() != 2 || done_cyc.size() != 1 || done_cyc[0] != s + 6) begin
            n_fail++;
            $display("FAIL abort_restart: got done=%0b %0d words done at cyc+%0d, want 2 words done at cyc+6",
                     ok, v_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] - s : -1);
        end
        for (int i = 0; i < v_cyc.size() && i < 2; i++) begin
            n_checks++;
            if (v_cyc[i] != s + 4 + i || v_kind[i] !== 4'b0010 || v_data[i] !== memf(16'h0005 + 16'(i))) begin
                n_fail++;
                $display("FAIL abort_restart_v[%0d]: got cyc+%0d kind %b data %h, want cyc+%0d kind 0010 data %h",
                         i, v_cyc[i] - s, v_kind[i], v_data[i], 4 + i, memf(16'h0005 + 16'(i)));
            end
        end
        $display("reset abort then restart: %0d words after restart", v_cyc.size());
    endtask

    initial begin
        test_reset();
        test_file_readback();
        test_pause();
        test_wrap();
        test_zero_length();
        test_mode_err_and_ignore();
        test_reset_abort();
        n_checks++;
        if (multi_cnt != 0) begin
            n_fail++;
            $display("FAIL one_hot_valid: got %0d cycles with several Valid_* high, want 0", multi_cnt);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation time limit, want test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
